// File: rtl/phase_seq_pkg.sv
// Shared definitions for the phase sequencer: state encoding and parameter checks.
package phase_seq_pkg;

  typedef enum logic [2:0] {
    S_INIT      = 3'd0,
    S_RST_PULSE = 3'd1,
    S_RUN       = 3'd2,
    S_HALT      = 3'd3,
    S_STEP      = 3'd4
  } seq_state_e;

  // Legal when every slot length fits in the slot counter and the basic minimums hold.
  function automatic bit params_ok(int np, int ph, int pg, int rc, int cw);
    int mx;
    mx = ph;
    if (pg > mx) mx = pg;
    if (rc > mx) mx = rc;
    return (np >= 2) && (ph >= 1) && (pg >= 0) && (rc >= 1) &&
           (cw >= 1) && (cw < 31) && (mx < (1 << cw));
  endfunction

endpackage

// File: rtl/phase_sequencer_slot_counter.sv
// Slot counter: walks HIGH/GAP slots over all phases of one machine cycle.
// Position describes the cycle currently presented on the phase outputs.
import phase_seq_pkg::*;

module phase_slot_counter #(
  parameter int NUM_PHASES = 2,
  parameter int PHASE_HIGH = 2,
  parameter int PHASE_GAP  = 1,
  parameter int CNT_W      = 8,
  parameter int IDX_W      = $clog2(NUM_PHASES)
) (
  input  logic                  internal_clock,
  input  logic                  reset,
  input  logic                  load,        // jump to first cycle of phase[0]
  input  logic                  advance,     // move to the following cycle
  output logic                  slot_done,   // last cycle of the current HIGH/GAP slot
  output logic                  cycle_done,  // current slot is the last slot of the machine cycle
  output logic [NUM_PHASES-1:0] next_phase   // phase vector of the following cycle
);

  localparam logic             HAS_GAP  = (PHASE_GAP > 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);
  localparam logic [CNT_W-1:0] HIGH_END = CNT_W'(PHASE_HIGH - 1);
  localparam logic [CNT_W-1:0] GAP_END  = HAS_GAP ? CNT_W'(PHASE_GAP - 1) : '0;

  logic [IDX_W-1:0] idx, nxt_idx;
  logic             gap, nxt_gap;
  logic [CNT_W-1:0] cnt, nxt_cnt;

  assign slot_done  = gap ? (cnt == GAP_END) : (cnt == HIGH_END);
  assign cycle_done = (idx == LAST_IDX) && (gap == HAS_GAP);

  // Successor position: HIGH slot -> GAP slot (if any) -> next phase, wrapping.
  always_comb begin
    nxt_idx = idx;
    nxt_gap = gap;
    nxt_cnt = cnt + 1'b1;
    if (slot_done) begin
      nxt_cnt = '0;
      if (!gap && HAS_GAP) begin
        nxt_gap = 1'b1;
      end else begin
        nxt_gap = 1'b0;
        nxt_idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
    end
  end

  // Decode the successor into a one-hot-or-zero phase vector.
  always_comb begin
    next_phase = '0;
    for (int k = 0; k < NUM_PHASES; k++)
      next_phase[k] = !nxt_gap && (nxt_idx == IDX_W'(k));
  end

  // Position register; load wins over advance, neither means hold.
  always_ff @(posedge internal_clock) begin
    if (!reset || load) begin
      idx <= '0;
      gap <= 1'b0;
      cnt <= '0;
    end else if (advance) begin
      idx <= nxt_idx;
      gap <= nxt_gap;
      cnt <= nxt_cnt;
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// Phase sequencer top: reset pulse, run/halt/step/restart FSM, freeze, cycle count.
import phase_seq_pkg::*;

module phase_sequencer #(
  parameter int NUM_PHASES   = 2,
  parameter int PHASE_HIGH   = 2,
  parameter int PHASE_GAP    = 1,
  parameter int RESET_CYCLES = 2,
  parameter int CNT_W        = 8
) (
  input  logic                  internal_clock,
  input  logic                  reset,
  input  logic                  controller_enable,
  input  logic                  halted,
  input  logic                  resume,
  input  logic                  step,
  input  logic                  restart,
  output logic [NUM_PHASES-1:0] phase,
  output logic                  cpu_reset,
  output logic                  cpu_enable,
  output logic [2:0]            seq_state,
  output logic [15:0]           mcycle_count
);

  if (!params_ok(NUM_PHASES, PHASE_HIGH, PHASE_GAP, RESET_CYCLES, CNT_W)) begin : g_bad_params
    $error("phase_sequencer: illegal parameter set");
  end

  localparam logic [CNT_W-1:0]      RST_END     = CNT_W'(RESET_CYCLES - 1);
  localparam logic [NUM_PHASES-1:0] FIRST_PHASE = NUM_PHASES'(1);

  seq_state_e                state;
  logic [CNT_W-1:0]          rst_cnt;
  logic [15:0]               mcycle_q;
  logic                      halt_latch;
  logic                      restart_pend;
  logic                      slot_done, cycle_done;
  logic [NUM_PHASES-1:0]     next_phase;
  logic                      slot_load, slot_adv;
  logic                      go_restart, running, mc_end;

  assign seq_state    = state;
  assign mcycle_count = mcycle_q;

  // A restart seen while frozen is held in restart_pend until re-enable.
  assign go_restart = controller_enable && (restart || restart_pend) && (state != S_INIT);
  assign running    = (state == S_RUN) || (state == S_STEP);
  assign mc_end     = running && slot_done && cycle_done;

  phase_slot_counter #(
    .NUM_PHASES (NUM_PHASES),
    .PHASE_HIGH (PHASE_HIGH),
    .PHASE_GAP  (PHASE_GAP),
    .CNT_W      (CNT_W)
  ) u_slot (
    .internal_clock (internal_clock),
    .reset          (reset),
    .load           (slot_load),
    .advance        (slot_adv),
    .slot_done      (slot_done),
    .cycle_done     (cycle_done),
    .next_phase     (next_phase)
  );

  // Counter control: restart to phase[0] whenever a machine cycle (re)starts.
  always_comb begin
    slot_load = 1'b0;
    slot_adv  = 1'b0;
    if (controller_enable && !go_restart) begin
      case (state)
        S_RST_PULSE: slot_load = (rst_cnt == RST_END);
        S_HALT:      slot_load = step || resume;
        S_RUN,
        S_STEP:      if (mc_end) slot_load = 1'b1; else slot_adv = 1'b1;
        default:     slot_load = 1'b0;
      endcase
    end
  end

  // Sequencer FSM with registered outputs; freeze only forces phase low.
  always_ff @(posedge internal_clock) begin
    if (!reset) begin
      state        <= S_INIT;
      phase        <= '0;
      cpu_reset    <= 1'b0;
      cpu_enable   <= 1'b0;
      mcycle_q     <= '0;
      halt_latch   <= 1'b0;
      rst_cnt      <= '0;
      restart_pend <= 1'b0;
    end else if (!controller_enable) begin
      phase <= '0;
      if (restart) restart_pend <= 1'b1;
    end else begin
      restart_pend <= 1'b0;
      if (go_restart) begin
        state      <= S_INIT;
        phase      <= '0;
        cpu_reset  <= 1'b0;
        cpu_enable <= 1'b0;
        halt_latch <= 1'b0;
      end else begin
        case (state)
          S_INIT: begin
            state      <= S_RST_PULSE;
            phase      <= '0;
            cpu_reset  <= 1'b1;
            cpu_enable <= 1'b1;
            rst_cnt    <= '0;
          end
          S_RST_PULSE: begin
            if (rst_cnt == RST_END) begin
              state     <= S_RUN;
              cpu_reset <= 1'b0;
              phase     <= FIRST_PHASE;
            end else begin
              rst_cnt <= rst_cnt + 1'b1;
            end
          end
          S_HALT: begin
            phase <= '0;
            if (step) begin
              state <= S_STEP;
              phase <= FIRST_PHASE;
            end else if (resume) begin
              state <= S_RUN;
              phase <= FIRST_PHASE;
            end
          end
          S_RUN: begin
            if (mc_end) begin
              mcycle_q <= mcycle_q + 16'd1;
              if (halt_latch || halted) begin
                state      <= S_HALT;
                phase      <= '0;
                halt_latch <= 1'b0;
              end else begin
                phase <= FIRST_PHASE;
              end
            end else begin
              phase <= next_phase;
              if (halted) halt_latch <= 1'b1;
            end
          end
          S_STEP: begin
            if (mc_end) begin
              mcycle_q <= mcycle_q + 16'd1;
              state    <= S_HALT;
              phase    <= '0;
            end else begin
              phase <= next_phase;
            end
          end
          default: begin
            state <= S_INIT;
            phase <= '0;
          end
        endcase
      end
    end
  end

endmodule
